// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI timing sequencer: FSM encoding, 720p default
// timing, and the colour-bar palette used when DVI_TEST_PATTERN_EN is defined.
package dvi_pkg;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned POS_W = 11;
  localparam int unsigned RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BACK   = 220;
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FRONT  = 110;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BACK   = 20;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FRONT  = 5;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Bar index (0 = leftmost) to colour
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvi_timing_cnt.sv
// Horizontal/vertical raster counters with clear/hold and wrap flags.
module dvi_timing_cnt
  import dvi_pkg::*;
#(
  parameter int unsigned H_TOTAL = 1650,
  parameter int unsigned V_TOTAL = 750
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             line_end_c_o,
  output logic             frame_end_c_o
);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  assign line_end_c_o  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
  assign frame_end_c_o = line_end_c_o && (v_cnt_q == CNT_W'(V_TOTAL - 1));
  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;

  // Next raster position: clear wins, otherwise advance when enabled
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (clr_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (en_i) begin
      if (line_end_c_o) begin
        h_cnt_d = '0;
        v_cnt_d = frame_end_c_o ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Video timing sequencer: run/idle FSM with frame-aligned stop, pixel request
// decode and a two-stage pipeline to the DVI transmitter.
// Optional build macro DVI_TEST_PATTERN_EN replaces source pixels with
// eight vertical colour bars.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             timing_en,
  input  logic [RGB_W-1:0] pixel_data,
  output logic             pixel_req,
  output logic [POS_W-1:0] pixel_xpos,
  output logic [POS_W-1:0] pixel_ypos,
  output logic [RGB_W-1:0] video_din,
  output logic             video_hsync,
  output logic             video_vsync,
  output logic             video_de,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_ACT_S = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_E = H_ACT_S + H_ACTIVE;
  localparam int unsigned V_ACT_S = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_E = V_ACT_S + V_ACTIVE;
  localparam logic        SYNC_ON  = SYNC_POL;
  localparam logic        SYNC_OFF = ~SYNC_POL;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             line_end_c, frame_end_c;
  logic             running_c, req_c, hs_c, vs_c;

  logic             run_p1_q, req_p1_q, hs_p1_q, vs_p1_q;
  logic             de_q, de_d;
  logic [RGB_W-1:0] din_q, din_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;

`ifdef DVI_TEST_PATTERN_EN
  logic [POS_W-1:0] x_p1_q;
  logic [2:0]       bar_idx_c;
  logic             unused_pixel_data;
  assign unused_pixel_data = ^pixel_data;
`endif

  assign running_c = (state_q != ST_IDLE);

  dvi_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .pclk_i        (pclk),
    .rst_i         (reset),
    .en_i          (running_c),
    .clr_i         (~running_c),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .line_end_c_o  (line_end_c),
    .frame_end_c_o (frame_end_c)
  );

  // Run/idle FSM: stopping is deferred to the last cycle of the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (timing_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!timing_en) state_d = frame_end_c ? ST_IDLE : ST_STOP_PEND;
      end
      ST_STOP_PEND: begin
        if (timing_en)        state_d = ST_RUN;
        else if (frame_end_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster decode for the current counter cycle
  always_comb begin
    req_c      = 1'b0;
    hs_c       = 1'b0;
    vs_c       = 1'b0;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (running_c) begin
      hs_c  = (h_cnt < CNT_W'(H_SYNC));
      vs_c  = (v_cnt < CNT_W'(V_SYNC));
      req_c = (h_cnt >= CNT_W'(H_ACT_S)) && (h_cnt < CNT_W'(H_ACT_E)) &&
              (v_cnt >= CNT_W'(V_ACT_S)) && (v_cnt < CNT_W'(V_ACT_E));
    end
    if (req_c) begin
      pixel_xpos = POS_W'(h_cnt - CNT_W'(H_ACT_S));
      pixel_ypos = POS_W'(v_cnt - CNT_W'(V_ACT_S));
    end
  end

  assign pixel_req = req_c;

`ifdef DVI_TEST_PATTERN_EN
  assign bar_idx_c = 3'((32'(x_p1_q) * 32'd8) / H_ACTIVE);
`endif

  // Second pipeline stage and status next values
  always_comb begin
    // A new frame begins whenever RUN follows idle or a frame wrap
    fs_d    = (state_d == ST_RUN) && (!running_c || frame_end_c);
    busy_d  = (state_d != ST_IDLE) || running_c || run_p1_q;
    de_d    = req_p1_q;
    hsync_d = hs_p1_q ? SYNC_ON : SYNC_OFF;
    vsync_d = vs_p1_q ? SYNC_ON : SYNC_OFF;
    din_d   = '0;
    if (req_p1_q) begin
`ifdef DVI_TEST_PATTERN_EN
      din_d = bar_colour(bar_idx_c);
`else
      din_d = pixel_data;
`endif
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_p1_q <= 1'b0;
      req_p1_q <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
`ifdef DVI_TEST_PATTERN_EN
      x_p1_q   <= '0;
`endif
      de_q     <= 1'b0;
      din_q    <= '0;
      hsync_q  <= SYNC_OFF;
      vsync_q  <= SYNC_OFF;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_p1_q <= running_c;
      req_p1_q <= req_c;
      hs_p1_q  <= hs_c;
      vs_p1_q  <= vs_c;
`ifdef DVI_TEST_PATTERN_EN
      x_p1_q   <= pixel_xpos;
`endif
      de_q     <= de_d;
      din_q    <= din_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
    end
  end

  assign video_de    = de_q;
  assign video_din   = din_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule
